// File: rtl/adder35_pkg.sv
// adder35_pkg: shared widths and types for the adder35 two-port sharing arbiter.
//   A_W / B_W / S_W : operand A, operand B and sum widths.
//   port_id_t       : requester id (0 or 1).
//   req_t           : one request's operands {a, b}.
package adder35_pkg;

  localparam int A_W = 35;
  localparam int B_W = 31;
  localparam int S_W = 36;

  typedef logic port_id_t;

  typedef struct packed {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
  } req_t;

  // Build a request from its two operands.
  function automatic req_t make_req(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_t r;
    r.a = a;
    r.b = b;
    return r;
  endfunction

endpackage

// File: rtl/adder35_share_arb_if.sv
// adder35_share_arb_if: bundles the two request channels, the response channel
// and the busy flag of adder35_share_arb.
//   slave  modport : the arbiter side (takes requests, drives responses).
//   master modport : the requester/consumer side.
interface adder35_share_arb_if;
  import adder35_pkg::*;

  logic           req0_valid;
  logic           req0_ready;
  logic [A_W-1:0] req0_a;
  logic [B_W-1:0] req0_b;
  logic           req1_valid;
  logic           req1_ready;
  logic [A_W-1:0] req1_a;
  logic [B_W-1:0] req1_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [S_W-1:0] rsp_sum;
  port_id_t       rsp_id;
  logic           busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_sum, rsp_id, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_sum, rsp_id, busy
  );

endinterface

// File: rtl/adder35_rr_pick2.sv
// adder35_rr_pick2: picks one of two valid requesters.
//   valid0/valid1 : requester valids.
//   grant         : one-hot grant (bit n = port n), zero when nobody is valid.
//   winner        : id of the granted port.
//   clk/rst/accept exist only with ADDER35_ARB_RR_EN: the last-winner pointer
//   moves to the current winner on an accepted transfer and resets to port 1.
// Without ADDER35_ARB_RR_EN port 0 has fixed priority.
module adder35_rr_pick2
  import adder35_pkg::*;
(
`ifdef ADDER35_ARB_RR_EN
  input  logic     clk,
  input  logic     rst,
  input  logic     accept,
`endif
  input  logic     valid0,
  input  logic     valid1,
  output logic [1:0] grant,
  output port_id_t winner
);

`ifdef ADDER35_ARB_RR_EN
  port_id_t last_q;
  port_id_t last_d;

  // Winner selection: on contention the port that did not win last goes first.
  always_comb begin
    winner = 1'b0;
    if (valid0 && valid1) begin
      winner = ~last_q;
    end else if (valid1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
    grant[0] = valid0 & ~winner;
    grant[1] = valid1 & winner;
    if (accept) begin
      last_d = winner;
    end else begin
      last_d = last_q;
    end
  end

  // Last-winner pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: port 1 only wins when port 0 is idle.
  always_comb begin
    winner = 1'b0;
    if (valid0) begin
      winner = 1'b0;
    end else if (valid1) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
    grant[0] = valid0 & ~winner;
    grant[1] = valid1 & winner;
  end
`endif

endmodule

// File: rtl/customAdder35_4.sv
// customAdder35_4: combinational 35-bit + zero-extended 31-bit adder.
//   a   : 35-bit operand.
//   b   : 31-bit operand, zero-extended.
//   sum : 36-bit result, carry-out in bit 35.
module customAdder35_4 (
  input  logic [34:0] a,
  input  logic [30:0] b,
  output logic [35:0] sum
);

  assign sum = {1'b0, a} + {5'b0_0000, b};

endmodule

// File: rtl/adder35_share_arb.sv
// adder35_share_arb: time-shares one 35+31-bit adder between two requesters.
//   clk, rst : clock and synchronous active-high reset.
//   bus      : request channels 0/1 (valid/ready/a/b), response channel
//              (valid/ready/sum/id) and busy, via adder35_share_arb_if.slave.
// Two-stage pipeline: S1 holds the granted operands, the adder works from S1,
// S2 holds the sum until the consumer takes it.
// Macro ADDER35_ARB_RR_EN selects round-robin arbitration; undefined gives
// fixed priority to port 0.
module adder35_share_arb
  import adder35_pkg::*;
(
  input  logic clk,
  input  logic rst,
  adder35_share_arb_if.slave bus
);

  logic           s1_vld_q, s1_vld_d;
  req_t           op_q, op_d;
  port_id_t       op_id_q, op_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [S_W-1:0] rsp_sum_q, rsp_sum_d;
  port_id_t       rsp_id_q, rsp_id_d;

  logic           s2_load;
  logic           s1_load;
  logic           ready0;
  logic           ready1;
  logic           accept;
  logic [1:0]     grant;
  port_id_t       winner;
  logic [S_W-1:0] add_sum;

  adder35_rr_pick2 u_pick (
`ifdef ADDER35_ARB_RR_EN
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
`endif
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .grant  (grant),
    .winner (winner)
  );

  customAdder35_4 u_add (
    .a   (op_q.a),
    .b   (op_q.b),
    .sum (add_sum)
  );

  // Handshake and next-state logic for both pipeline stages.
  always_comb begin
    s2_load = ~rsp_valid_q | bus.rsp_ready;
    s1_load = ~s1_vld_q | s2_load;
    // Readies are forced low during reset so nothing is accepted in that cycle.
    ready0  = grant[0] & s1_load & ~rst;
    ready1  = grant[1] & s1_load & ~rst;
    accept  = ready0 | ready1;

    s1_vld_d = s1_vld_q;
    op_d     = op_q;
    op_id_d  = op_id_q;
    if (accept) begin
      s1_vld_d = 1'b1;
      op_id_d  = winner;
      if (winner) begin
        op_d = make_req(bus.req1_a, bus.req1_b);
      end else begin
        op_d = make_req(bus.req0_a, bus.req0_b);
      end
    end else if (s2_load) begin
      s1_vld_d = 1'b0;
    end else begin
      s1_vld_d = s1_vld_q;
    end

    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_id_d    = rsp_id_q;
    if (s2_load) begin
      rsp_valid_d = s1_vld_q;
      // Data only moves when S1 holds something, so an idle S2 keeps its last value.
      if (s1_vld_q) begin
        rsp_sum_d = add_sum;
        rsp_id_d  = op_id_q;
      end else begin
        rsp_sum_d = rsp_sum_q;
        rsp_id_d  = rsp_id_q;
      end
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      op_q        <= '0;
      op_id_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= {S_W{1'b0}};
      rsp_id_q    <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      op_q        <= op_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_sum    = rsp_sum_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.busy       = s1_vld_q | rsp_valid_q;

endmodule

// File: tb/tb_adder35_share_arb.sv
`timescale 1ns/1ps
module tb_adder35_share_arb;
  import adder35_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adder35_share_arb_if bus ();

  adder35_share_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: expected results in acceptance order, observed
  // results in delivery order, expected/observed arbitration picks.
  logic [35:0] exp_sum_q[$];
  logic        exp_id_q[$];
  logic [35:0] obs_sum_q[$];
  logic        obs_id_q[$];
  int          pick_exp_q[$];
  int          pick_obs_q[$];
  logic        model_last = 1'b1;

  logic        s_r0, s_r1, s_rv, s_rid, s_busy;
  logic [35:0] s_rsum;
  bit          acc0, acc1;

  function automatic logic [35:0] ref_sum(input logic [34:0] a, input logic [30:0] b);
    return 36'(a) + 36'(b);
  endfunction

  // One clock: sample at negedge, log transfers into the model, return at posedge+1.
  task automatic tick();
    int pick;
    @(negedge clk);
    s_r0 = bus.req0_ready; s_r1 = bus.req1_ready;
    s_rv = bus.rsp_valid; s_rid = bus.rsp_id; s_rsum = bus.rsp_sum; s_busy = bus.busy;
    acc0 = s_r0 && bus.req0_valid && !rst;
    acc1 = s_r1 && bus.req1_valid && !rst;
    if (!rst) begin
      if (acc0 || acc1) begin
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ADDER35_ARB_RR_EN
          pick = model_last ? 0 : 1;
`else
          pick = 0;
`endif
        end else begin
          pick = bus.req1_valid ? 1 : 0;
        end
        pick_exp_q.push_back(pick);
        pick_obs_q.push_back((acc0 && acc1) ? 2 : (acc1 ? 1 : 0));
        model_last = (pick == 1);
      end
      if (acc0) begin exp_sum_q.push_back(ref_sum(bus.req0_a, bus.req0_b)); exp_id_q.push_back(1'b0); end
      if (acc1) begin exp_sum_q.push_back(ref_sum(bus.req1_a, bus.req1_b)); exp_id_q.push_back(1'b1); end
      if (s_rv && bus.rsp_ready) begin obs_sum_q.push_back(s_rsum); obs_id_q.push_back(s_rid); end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      // Everything accepted but not yet delivered is discarded by reset.
      while (exp_sum_q.size() > obs_sum_q.size()) begin
        void'(exp_sum_q.pop_back());
        void'(exp_id_q.pop_back());
      end
      model_last = 1'b1;
    end
  endtask

  task automatic new_op0();
    logic [63:0] t;
    t = {$urandom(), $urandom()}; bus.req0_a = t[34:0];
    t = {$urandom(), $urandom()}; bus.req0_b = t[30:0];
  endtask

  task automatic new_op1();
    logic [63:0] t;
    t = {$urandom(), $urandom()}; bus.req1_a = t[34:0];
    t = {$urandom(), $urandom()}; bus.req1_b = t[30:0];
  endtask

  task automatic clear_q();
    exp_sum_q.delete(); exp_id_q.delete(); obs_sum_q.delete(); obs_id_q.delete();
    pick_exp_q.delete(); pick_obs_q.delete();
  endtask

  // Stop requesting and run until every accepted result has come out (bounded).
  task automatic drain(output bit tmo);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
    tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!s_busy && obs_sum_q.size() == exp_sum_q.size()) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
    new_op0(); new_op1();
    tick(); tick();
    vectors++;
    if (s_r0 !== 1'b0 || s_r1 !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready got %b%b want 00", s_r0, s_r1);
    end
    rst = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
    vectors++;
    if (s_rv !== 1'b0 || s_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_state valid/busy got %b%b want 00", s_rv, s_busy);
    end
    vectors++;
    if (s_rsum !== 36'h0 || s_rid !== 1'b0) begin
      miscompares++; $display("FAIL reset_data got sum=%h id=%b want 0/0", s_rsum, s_rid);
    end
    clear_q();
  endtask

  task automatic test_single();
    clear_q();
    bus.rsp_ready = 1'b1;
    bus.req0_a = 35'h7_FFFF_FFFF; bus.req0_b = 31'h1; bus.req0_valid = 1'b1;
    tick();
    vectors++;
    if (s_r0 !== 1'b1) begin miscompares++; $display("FAIL single_zero_wait got ready0=%b want 1", s_r0); end
    bus.req0_valid = 1'b0;
    tick();
    vectors++;
    if (s_rv !== 1'b0 || s_busy !== 1'b1) begin
      miscompares++; $display("FAIL single_s1 got valid=%b busy=%b want 0/1", s_rv, s_busy);
    end
    tick();
    vectors++;
    if (s_rv !== 1'b1 || s_rsum !== 36'h8_0000_0000 || s_rid !== 1'b0) begin
      miscompares++; $display("FAIL single_result got v=%b sum=%h id=%b want 1/800000000/0", s_rv, s_rsum, s_rid);
    end
    tick();
    vectors++;
    if (s_rv !== 1'b0 || obs_sum_q.size() != 1) begin
      miscompares++; $display("FAIL single_once got v=%b count=%0d want 0/1", s_rv, obs_sum_q.size());
    end
    clear_q();
  endtask

  task automatic test_alternate();
    bit tmo;
    clear_q();
    new_op0(); new_op1();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (!(acc0 || acc1)) begin miscompares++; $display("FAIL alt_throughput cycle %0d got no accept want one", i); end
      if (acc0) new_op0();
      if (acc1) new_op1();
    end
    drain(tmo);
    vectors++;
    if (tmo || obs_sum_q.size() != exp_sum_q.size()) begin
      miscompares++; $display("FAIL alt_count got %0d want %0d", obs_sum_q.size(), exp_sum_q.size());
    end
    foreach (exp_sum_q[i]) if (i < obs_sum_q.size()) begin
      vectors++;
      if (obs_sum_q[i] !== exp_sum_q[i] || obs_id_q[i] !== exp_id_q[i]) begin
        miscompares++; $display("FAIL alt_data[%0d] got %h/%b want %h/%b", i, obs_sum_q[i], obs_id_q[i], exp_sum_q[i], exp_id_q[i]);
      end
    end
    foreach (pick_exp_q[i]) begin
      vectors++;
      if (pick_obs_q[i] !== pick_exp_q[i]) begin
        miscompares++; $display("FAIL alt_grant[%0d] got %0d want %0d", i, pick_obs_q[i], pick_exp_q[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_backpressure();
    bit tmo;
    int accepts;
    clear_q();
    accepts = 0;
    new_op0(); new_op1();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (acc0 || acc1) accepts++;
      if (acc0) new_op0();
      if (acc1) new_op1();
    end
    vectors++;
    if (accepts != 2) begin miscompares++; $display("FAIL bp_accepts got %0d want 2", accepts); end
    vectors++;
    if (s_r0 !== 1'b0 || s_r1 !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got %b%b want 00", s_r0, s_r1); end
    bus.rsp_ready = 1'b1;
    tick();
    vectors++;
    if (!(acc0 || acc1)) begin miscompares++; $display("FAIL bp_release_accept got none want one"); end
    drain(tmo);
    vectors++;
    if (tmo || obs_sum_q.size() != 3 || exp_sum_q.size() != 3) begin
      miscompares++; $display("FAIL bp_count got %0d want 3", obs_sum_q.size());
    end
    foreach (exp_sum_q[i]) if (i < obs_sum_q.size()) begin
      vectors++;
      if (obs_sum_q[i] !== exp_sum_q[i] || obs_id_q[i] !== exp_id_q[i]) begin
        miscompares++; $display("FAIL bp_data[%0d] got %h/%b want %h/%b", i, obs_sum_q[i], obs_id_q[i], exp_sum_q[i], exp_id_q[i]);
      end
    end
    foreach (pick_exp_q[i]) begin
      vectors++;
      if (pick_obs_q[i] !== pick_exp_q[i]) begin
        miscompares++; $display("FAIL bp_grant[%0d] got %0d want %0d", i, pick_obs_q[i], pick_exp_q[i]);
      end
    end
    clear_q();
  endtask

  task automatic test_max();
    bit tmo;
    clear_q();
    bus.req1_a = 35'h7_FFFF_FFFF; bus.req1_b = 31'h7FFF_FFFF;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
    tick();
    bus.req1_valid = 1'b0;
    drain(tmo);
    vectors++;
    if (tmo || obs_sum_q.size() != 1) begin
      miscompares++; $display("FAIL max_count got %0d want 1", obs_sum_q.size());
    end else if (obs_sum_q[0] !== 36'h8_7FFF_FFFE || obs_id_q[0] !== 1'b1) begin
      miscompares++; $display("FAIL max_sum got %h/%b want 87fffffffe/1", obs_sum_q[0], obs_id_q[0]);
    end
    clear_q();
  endtask

  task automatic test_mid_reset();
    bit tmo;
    clear_q();
    new_op0(); new_op1();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (acc0) new_op0();
      if (acc1) new_op1();
    end
    vectors++;
    if (s_rv !== 1'b1 || s_busy !== 1'b1) begin
      miscompares++; $display("FAIL mrst_full got v=%b busy=%b want 1/1", s_rv, s_busy);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (s_r0 !== 1'b0 || s_r1 !== 1'b0) begin miscompares++; $display("FAIL mrst_ready got %b%b want 00", s_r0, s_r1); end
    rst = 1'b0;
    new_op0(); new_op1();
    bus.rsp_ready = 1'b1;
    tick();
    vectors++;
    if (s_rv !== 1'b0 || s_busy !== 1'b0) begin
      miscompares++; $display("FAIL mrst_empty got v=%b busy=%b want 0/0", s_rv, s_busy);
    end
    vectors++;
    if (s_r0 !== 1'b1 || s_r1 !== 1'b0) begin
      miscompares++; $display("FAIL mrst_first_grant got %b%b want r0=1 r1=0", s_r0, s_r1);
    end
    drain(tmo);
    vectors++;
    if (tmo || obs_sum_q.size() != 1 || exp_sum_q.size() != 1) begin
      miscompares++; $display("FAIL mrst_count got %0d want 1", obs_sum_q.size());
    end else if (obs_sum_q[0] !== exp_sum_q[0] || obs_id_q[0] !== 1'b0) begin
      miscompares++; $display("FAIL mrst_data got %h/%b want %h/0", obs_sum_q[0], obs_id_q[0], exp_sum_q[0]);
    end
    clear_q();
  endtask

`ifndef ADDER35_ARB_RR_EN
  task automatic test_fixed_priority();
    bit tmo;
    clear_q();
    new_op0(); new_op1();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (s_r0 !== 1'b1 || s_r1 !== 1'b0) begin
        miscompares++; $display("FAIL fixed_grant cycle %0d got %b%b want r0=1 r1=0", i, s_r0, s_r1);
      end
      if (acc0) new_op0();
    end
    drain(tmo);
    vectors++;
    if (tmo || obs_sum_q.size() != 4) begin
      miscompares++; $display("FAIL fixed_count got %0d want 4", obs_sum_q.size());
    end
    foreach (exp_sum_q[i]) if (i < obs_sum_q.size()) begin
      vectors++;
      if (obs_sum_q[i] !== exp_sum_q[i] || obs_id_q[i] !== 1'b0) begin
        miscompares++; $display("FAIL fixed_data[%0d] got %h/%b want %h/0", i, obs_sum_q[i], obs_id_q[i], exp_sum_q[i]);
      end
    end
    clear_q();
  endtask
`endif

  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req0_a = 35'h0; bus.req0_b = 31'h0; bus.req1_a = 35'h0; bus.req1_b = 31'h0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_max();
    test_mid_reset();
`ifndef ADDER35_ARB_RR_EN
    test_fixed_priority();
`endif
    test_alternate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder35_share_arb.md
# adder35_share_arb

Two-port arbiter and sequencer that time-shares one 35-bit + 31-bit zero-extending adder between two requesters. Each requester uses its own valid/ready channel. The block returns each 36-bit sum, tagged with the requester id, on a single response channel that supports backpressure. It sits in the multiply/accumulate datapath wherever two partial-sum producers would otherwise need two adder instances.

## Interface
Parameters:
- none; all widths are fixed by package constants.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active high.
- req0_valid  in  1  port 0 operands valid.
- req0_ready  out  1  port 0 transfer accepted this cycle.
- req0_a  in  35  port 0 operand A.
- req0_b  in  31  port 0 operand B, zero-extended to 35 bits.
- req1_valid / req1_ready / req1_a / req1_b: same as port 0, for port 1.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  36  A + zext(B).
- rsp_id  out  1  originating port.
- busy  out  1  any pipeline stage occupied.

## Operation
- Transfer on port n occurs when reqn_valid & reqn_ready. Result transfer occurs when rsp_valid & rsp_ready.
- Requesters hold valid and operands stable until accepted. reqn_ready may depend combinationally on both req valids and on rsp_ready; valid must never depend on ready.
- At most one port is granted per cycle.
  - Only one port valid: that port is granted.
  - Both ports valid: the port that did not win the last accepted transfer is granted.
  - The last-winner pointer updates only on an accepted transfer; after reset it points to port 1, so port 0 wins first.
- Pipeline stage S1 (operand register): holds op_a, op_b, op_id and s1_vld. The adder evaluates combinationally from the S1 registers.
- Pipeline stage S2 (result register): holds rsp_sum, rsp_id and rsp_valid.
- Advance rules:
  - S2 loads when !rsp_valid | rsp_ready.
  - S1 loads a new request when !s1_vld | S2 loads.
  - reqn_ready = grant_n & (S1 can load).
- Arithmetic: rsp_sum = {0, A} + {0, 4'b0, B}, 36 bits, no truncation. The carry-out always lands in bit 35. Maximum value is 36'h8_7FFF_FFFE.
- Ordering: results leave in acceptance order. No drop or duplication under any backpressure pattern.
- busy = s1_vld | rsp_valid.
- Reset values: s1_vld=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0, pointer=port 1, req ready outputs low.
- Reset mid-operation: all in-flight operations are discarded and no response is produced for them. Requests valid during the reset cycle are not accepted.

## Timing
- Latency: accept at edge N puts the result on rsp_valid after edge N+1, i.e. 2 cycles, with rsp_ready held high.
- Throughput: one accept per cycle with rsp_ready=1.
- Full pipeline: S1 and S2 both occupied with rsp_ready=0. Both req ready outputs are low.
- On the cycle rsp_ready rises with the pipeline full: S2 takes S1, and S1 accepts a new request in the same cycle.
- Empty pipeline: a lone request is accepted with zero wait.

## Configuration
- ADDER35_ARB_RR_EN defined: round-robin last-winner arbitration, as above.
- ADDER35_ARB_RR_EN undefined:
  - Fixed priority; port 0 always wins when both ports are valid.
  - Pointer register removed.
  - Port 1 may starve; this is intended for callers where port 1 is a background producer.

## Structure
- Shared package adder35_pkg:
  - constants A_W=35, B_W=31, S_W=36;
  - typedef port_id_t (1 bit);
  - typedef req_t {a, b}.
- Sub-module adder35_rr_pick2: two valids in, pointer state in, grant one-hot out, winner out. It is purely combinational, plus the pointer register when ADDER35_ARB_RR_EN is defined.
- The datapath instantiates the existing customAdder35_4 unchanged, fed from the S1 registers.

## Test plan
- Single port 0 request, a=35'h7_FFFF_FFFF, b=31'h1, rsp_ready=1 → after 2 cycles rsp_sum=36'h8_0000_0000, rsp_id=0, exactly one response.
- Both ports valid continuously with distinct operands, rsp_ready=1 → ids alternate 0,1,0,1,… at one result per cycle, and all sums are correct.
- Streaming requests with rsp_ready held low for 5 cycles → at most 2 accepted, both req ready outputs low, responses preserved in order when ready returns.
- Both operands all ones on port 1 → rsp_sum=36'h8_7FFF_FFFE, rsp_id=1.
- rst asserted for 1 cycle while S1 and S2 are both occupied → rsp_valid=0 and busy=0 next cycle; no stale response; the next simultaneous request is granted to port 0.
- Build without ADDER35_ARB_RR_EN, both ports valid for 4 cycles → all 4 grants to port 0, port 1 ready stays low.
